// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns unit with a valid/ready handshake.
// COLS_PER_CYCLE column engines are reused over N_ITER busy cycles per 128-bit block.

// One 32-bit column through both the forward and inverse matrices; inv picks the result.
module mix_column_engine (
  input  logic        inv,
  input  logic [31:0] col,
  output logic [31:0] res_c
);

  localparam int unsigned N_ROWS = 4;
  localparam int unsigned BYTE_W = 8;

  // Multiplication by 2 in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] xtime(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  logic [BYTE_W-1:0] a   [N_ROWS];
  logic [BYTE_W-1:0] x2  [N_ROWS];
  logic [BYTE_W-1:0] x4  [N_ROWS];
  logic [BYTE_W-1:0] x8  [N_ROWS];
  logic [BYTE_W-1:0] m3  [N_ROWS];
  logic [BYTE_W-1:0] m9  [N_ROWS];
  logic [BYTE_W-1:0] mb  [N_ROWS];
  logic [BYTE_W-1:0] md  [N_ROWS];
  logic [BYTE_W-1:0] me  [N_ROWS];
  logic [BYTE_W-1:0] fwd [N_ROWS];
  logic [BYTE_W-1:0] bwd [N_ROWS];

  // Per-byte constant multiples, built from a shared xtime chain.
  always_comb begin
    for (int i = 0; i < N_ROWS; i++) begin
      a[i]  = col[31-8*i -: 8];
      x2[i] = xtime(a[i]);
      x4[i] = xtime(x2[i]);
      x8[i] = xtime(x4[i]);
      m3[i] = x2[i] ^ a[i];
      m9[i] = x8[i] ^ a[i];
      mb[i] = x8[i] ^ x2[i] ^ a[i];
      md[i] = x8[i] ^ x4[i] ^ a[i];
      me[i] = x8[i] ^ x4[i] ^ x2[i];
    end
  end

  // Circulant row sums; row r rotates the coefficient vector right by r.
  always_comb begin
    res_c = '0;
    for (int r = 0; r < N_ROWS; r++) begin
      fwd[r] = x2[r] ^ m3[2'(r + 1)] ^ a[2'(r + 2)] ^ a[2'(r + 3)];
      bwd[r] = me[r] ^ mb[2'(r + 1)] ^ md[2'(r + 2)] ^ m9[2'(r + 3)];
      res_c[31-8*r -: 8] = inv ? bwd[r] : fwd[r];
    end
  end

endmodule

module mix_columns_iter #(
  parameter int unsigned COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         in_inv,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned N_COLS = 4;
  localparam int unsigned COL_W  = 32;
  localparam int unsigned IDX_W  = 2;
  localparam int unsigned CPC    = (COLS_PER_CYCLE == 0) ? 1 : COLS_PER_CYCLE;
  localparam int unsigned N_ITER = N_COLS / CPC;
  localparam int unsigned CNT_W  = (N_ITER > 1) ? $clog2(N_ITER) : 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N_ITER - 1);

  // Only 1, 2 or 4 engines divide the four columns evenly.
  generate
    if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cpc
      $error("mix_columns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 accept_c;
  logic [CNT_W-1:0]     iter_q;
  logic                 mode_q;
  logic [COL_W-1:0]     cols_q  [N_COLS];
  logic [IDX_W-1:0]     col_idx [CPC];
  logic [COL_W-1:0]     eng_in  [CPC];
  logic [COL_W-1:0]     eng_out [CPC];

  // Next-state logic; a block is taken only while idle.
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          accept_c = 1'b1;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        if (iter_q == LAST_ITER) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with status flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  // Iteration counter: cleared on accept, advances through BUSY, parks on the last slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iter_q <= '0;
    end else if (accept_c) begin
      iter_q <= '0;
    end else if (state_q == BUSY && iter_q != LAST_ITER) begin
      iter_q <= iter_q + CNT_W'(1);
    end
  end

  // Direction is captured with the block so later in_inv changes cannot affect it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 1'b0;
    end else if (accept_c) begin
      mode_q <= in_inv;
    end
  end

  // Column slice handled this iteration; column 0 (MSBs) goes first.
  always_comb begin
    for (int unsigned k = 0; k < CPC; k++) begin
      col_idx[k] = IDX_W'(32'(iter_q) * CPC + k);
      eng_in[k]  = cols_q[col_idx[k]];
    end
  end

  // Shared column engines, reused across iterations.
  generate
    for (genvar k = 0; k < CPC; k++) begin : g_eng
      mix_column_engine u_eng (
        .inv   (mode_q),
        .col   (eng_in[k]),
        .res_c (eng_out[k])
      );
    end
  endgenerate

  // State register: load on accept, overwrite the active slice in place while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_COLS; i++) begin
        cols_q[i] <= '0;
      end
    end else if (accept_c) begin
      for (int i = 0; i < N_COLS; i++) begin
        cols_q[i] <= in_data[127-32*i -: 32];
      end
    end else if (state_q == BUSY) begin
      for (int unsigned k = 0; k < CPC; k++) begin
        cols_q[col_idx[k]] <= eng_out[k];
      end
    end
  end

  // Result is the state register itself, so it holds while stalled.
  assign out_data = {cols_q[0], cols_q[1], cols_q[2], cols_q[3]};

endmodule

// File: tb/tb_mix_columns_iter.sv
// Scoreboard bench for mix_columns_iter: three instances (1, 2, 4 columns per cycle)
// share stimulus; per-instance monitors check handshake timing and result data.
module tb_mix_columns_iter;

  localparam int unsigned N_DUT = 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_inv;
  logic [127:0] in_data;
  logic         out_ready = 1'b1;

  logic         in_ready_w  [N_DUT];
  logic         out_valid_w [N_DUT];
  logic         busy_w      [N_DUT];
  logic [127:0] out_data_w  [N_DUT];

  logic [127:0] exp_q [N_DUT][$];

  int           compared   = 0;
  int           mismatched = 0;
  logic         rnd_mode   = 1'b0;
  logic         ready_hold = 1'b1;

  localparam logic [127:0] F1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [127:0] F1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [127:0] F2_IN  = 128'hd4d4d4d5_db135345_f20a225c_c6c6c6c6;
  localparam logic [127:0] F2_OUT = 128'hd5d5d7d6_8e4da1bc_9fdc589d_c6c6c6c6;
  localparam logic [127:0] F3_IN  = 128'h2d26314c_01010101_d4d4d4d5_f20a225c;
  localparam logic [127:0] F3_OUT = 128'h4d7ebdf8_01010101_d5d5d7d6_9fdc589d;

  always #5 clk = ~clk;

  // Downstream ready: either a held level or random stalls.
  always @(posedge clk) begin
    #2;
    out_ready = rnd_mode ? ($urandom_range(0, 3) != 0) : ready_hold;
  end

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: generic GF(2^8) multiply and circulant matrix product.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = aa[7] ? (8'({aa[6:0], 1'b0}) ^ 8'h1b) : 8'({aa[6:0], 1'b0});
    end
    return p;
  endfunction

  function automatic logic [7:0] coef(input logic inv, input int k);
    case (k)
      0: return inv ? 8'h0e : 8'h02;
      1: return inv ? 8'h0b : 8'h03;
      2: return inv ? 8'h0d : 8'h01;
      default: return inv ? 8'h09 : 8'h01;
    endcase
  endfunction

  function automatic logic [127:0] model_block(input logic [127:0] x, input logic inv);
    logic [127:0] y = '0;
    logic [7:0]   acc;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++) begin
          acc = acc ^ gmul(x[127-32*c-8*j -: 8], coef(inv, (j - r + 4) % 4));
        end
        y[127-32*c-8*r -: 8] = acc;
      end
    end
    return y;
  endfunction

  function automatic logic all_ready();
    return in_ready_w[0] && in_ready_w[1] && in_ready_w[2];
  endfunction

  function automatic logic all_empty();
    return exp_q[0].size() == 0 && exp_q[1].size() == 0 && exp_q[2].size() == 0;
  endfunction

  // Instances plus a per-instance timing model and scoreboard monitor.
  for (genvar g = 0; g < N_DUT; g++) begin : g_dut
    localparam int unsigned CPC = 1 << g;
    localparam int unsigned NIT = 4 / CPC;
    int unsigned  mst;
    int unsigned  mcnt;
    logic [127:0] exp_v;
    logic [2:0]   flags_exp;

    mix_columns_iter #(.COLS_PER_CYCLE(CPC)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_w[g]),
      .in_inv    (in_inv),
      .in_data   (in_data),
      .out_valid (out_valid_w[g]),
      .out_ready (out_ready),
      .out_data  (out_data_w[g]),
      .busy      (busy_w[g])
    );

    always @(negedge clk) begin
      if (!rst_n) begin
        mst  = 0;
        mcnt = 0;
      end else begin
        flags_exp = {mst == 0, mst == 2, mst != 0};
        check($sformatf("cpc%0d ready/valid/busy", CPC),
              128'({in_ready_w[g], out_valid_w[g], busy_w[g]}), 128'(flags_exp));
        if (out_valid_w[g] && out_ready) begin
          if (exp_q[g].size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL cpc%0d unexpected output: got %h want none", CPC, out_data_w[g]);
          end else begin
            exp_v = exp_q[g].pop_front();
            check($sformatf("cpc%0d data", CPC), out_data_w[g], exp_v);
          end
        end
        case (mst)
          0: if (in_valid) begin mst = 1; mcnt = 0; end
          1: begin mcnt++; if (mcnt == NIT) mst = 2; end
          default: if (out_ready) mst = 0;
        endcase
      end
    end
  end

  // Issue one block to all instances once all are idle; scrambles inputs afterwards.
  task automatic send(input logic [127:0] d, input logic inv, input logic [127:0] exp);
    int unsigned n = 0;
    while (!all_ready() && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!all_ready()) begin
      compared++;
      mismatched++;
      $display("FAIL send timeout: got in_ready low want high");
      return;
    end
    in_valid = 1'b1;
    in_data  = d;
    in_inv   = inv;
    for (int i = 0; i < N_DUT; i++) exp_q[i].push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_inv   = ~inv;
    in_data  = ~d;
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (!all_empty() && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    if (!all_empty()) begin
      compared++;
      mismatched++;
      $display("FAIL drain timeout: got %0d pending want 0", exp_q[0].size());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] x;
    logic [127:0] y;
    logic         inv;
    int unsigned  n;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_inv   = 1'b0;
    in_data  = '0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < N_DUT; i++) begin
      check("reset out_data", out_data_w[i], '0);
      check("reset flags", 128'({in_ready_w[i], out_valid_w[i], busy_w[i]}), 128'(3'b100));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed known-answer vectors, both directions.
    send(F1_IN,  1'b0, F1_OUT);
    send(F1_OUT, 1'b1, F1_IN);
    send(F2_IN,  1'b0, F2_OUT);
    send(F2_OUT, 1'b1, F2_IN);
    send(F3_IN,  1'b0, F3_OUT);
    send(F3_OUT, 1'b1, F3_IN);
    drain();

    // Backpressure: result must hold and new blocks must be refused.
    ready_hold = 1'b0;
    send(F1_IN, 1'b0, F1_OUT);
    n = 0;
    while (!out_valid_w[0] && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      in_inv   = 1'b1;
      in_data  = F2_IN;
      check("stall data", out_data_w[0], F1_OUT);
      check("stall flags", 128'({in_ready_w[0], out_valid_w[0]}), 128'(2'b01));
      @(posedge clk); #1;
    end
    in_valid   = 1'b0;
    ready_hold = 1'b1;
    @(posedge clk); #1;
    check("release flags", 128'({in_ready_w[0], out_valid_w[0]}), 128'(2'b10));
    send(F3_OUT, 1'b1, F3_IN);
    check("accept after release", 128'(busy_w[0]), 128'(1'b1));
    drain();

    // Reset in the middle of an iteration (counter at 2 for one column per cycle).
    send(F2_IN, 1'b0, F2_OUT);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    for (int i = 0; i < N_DUT; i++) exp_q[i].delete();
    #1;
    check("midreset out_data", out_data_w[0], '0);
    check("midreset flags", 128'({in_ready_w[0], out_valid_w[0], busy_w[0]}), 128'(3'b100));
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(F1_IN, 1'b0, F1_OUT);
    drain();

    // Random round trips with random stalls.
    rnd_mode = 1'b1;
    for (int k = 0; k < 500; k++) begin
      x   = {$urandom(), $urandom(), $urandom(), $urandom()};
      inv = 1'($urandom_range(0, 1));
      y   = model_block(x, inv);
      send(x, inv, y);
      send(y, ~inv, x);
    end
    rnd_mode = 1'b0;
    drain();
    repeat (3) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
